// File: rtl/ortree_pipe_if.sv
// Handshake bundle between the alignment shifter, the pipelined OR/AND tree and the rounding unit.
interface ortree_pipe_if #(
  parameter int N = 64
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic         in_op;
  logic         in_first;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic         or_out;
  logic         sticky_out;
  logic         out_last;
  logic         out_orphan;

  modport master (
    output in_valid, x, in_op, in_first, in_last, out_ready,
    input  in_ready, out_valid, or_out, sticky_out, out_last, out_orphan
  );

  modport slave (
    input  in_valid, x, in_op, in_first, in_last, out_ready,
    output in_ready, out_valid, or_out, sticky_out, out_last, out_orphan
  );
endinterface

// File: rtl/ortree_pipe.sv
// Pipelined OR/AND reduction tree with a per-packet sticky accumulator.
// Registers sit every LEVELS_PER_STAGE tree levels; the final stage also folds the beat into the packet result.
module ortree_pipe #(
  parameter int N                = 64,
  parameter int LEVELS_PER_STAGE = 2
) (
  input logic          clk,
  input logic          reset,
  ortree_pipe_if.slave pipe
);

  localparam int DEPTH = $clog2(N);
  localparam int LAT   = (DEPTH == 0) ? 1 : (DEPTH + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
  // One spare bit so the pairing loop never indexes past the vector for odd widths.
  localparam int NP    = N + 1;

  function automatic int widthAfter(input int levels);
    int w;
    w = N;
    for (int k = 0; k < levels; k++) w = (w + 1) / 2;
    return w;
  endfunction

  function automatic int levelsIn(input int stage);
    int rem;
    rem = DEPTH - stage * LEVELS_PER_STAGE;
    if (rem < 0) rem = 0;
    if (rem > LEVELS_PER_STAGE) rem = LEVELS_PER_STAGE;
    return rem;
  endfunction

  function automatic logic [NP-1:0] pairLevel(input logic [NP-1:0] v, input int w, input logic op);
    logic [NP-1:0] r;
    r = '0;
    for (int j = 0; j < NP / 2; j++) begin
      if (2 * j + 1 < w) r[j] = op ? (v[2*j] & v[2*j+1]) : (v[2*j] | v[2*j+1]);
      else if (2 * j < w) r[j] = v[2*j];
    end
    return r;
  endfunction

  function automatic logic [NP-1:0] reduceStage(input logic [NP-1:0] v, input int w,
                                                input int levels, input logic op);
    logic [NP-1:0] cur;
    int            cw;
    cur = v;
    cw  = w;
    for (int k = 0; k < LEVELS_PER_STAGE; k++) begin
      if (k < levels) begin
        cur = pairLevel(cur, cw, op);
        cw  = (cw + 1) / 2;
      end
    end
    return cur;
  endfunction

  logic [LAT-1:0]         stageValid_q, stageOp_q, stageFirst_q, stageLast_q, stageOrphan_q;
  logic [LAT-1:0][NP-1:0] stageVec_q;
  logic [LAT-1:0]         inValid, inOp, inFirst, inLast, inOrphan, advance;
  logic [LAT-1:0][NP-1:0] inVec, nextVec;
  logic                   inPacket_q, inPacket_d, acc_q, acc_d;
  logic                   accept, orphanIn, finalRed, finalFirst;

  for (genvar s = 0; s < LAT; s++) begin : gStage
    localparam int WIN = widthAfter(s * LEVELS_PER_STAGE);
    localparam int NLV = levelsIn(s);
    if (s == 0) begin : gHead
      assign inValid[s]  = pipe.in_valid;
      assign inVec[s]    = {1'b0, pipe.x};
      assign inOp[s]     = pipe.in_op;
      assign inFirst[s]  = pipe.in_first;
      assign inLast[s]   = pipe.in_last;
      assign inOrphan[s] = orphanIn;
    end else begin : gBody
      assign inValid[s]  = stageValid_q[s-1];
      assign inVec[s]    = stageVec_q[s-1];
      assign inOp[s]     = stageOp_q[s-1];
      assign inFirst[s]  = stageFirst_q[s-1];
      assign inLast[s]   = stageLast_q[s-1];
      assign inOrphan[s] = stageOrphan_q[s-1];
    end
    assign nextVec[s] = reduceStage(inVec[s], WIN, NLV, inOp[s]);
  end

  // Back-pressure ripples combinationally from out_ready to in_ready; there is no skid storage.
  always_comb begin : advChain
    logic [LAT-1:0] a;
    a = '0;
    a[LAT-1] = !stageValid_q[LAT-1] || pipe.out_ready;
    for (int s = LAT - 2; s >= 0; s--) a[s] = !stageValid_q[s] || a[s+1];
    advance = a;
  end

  always_comb begin
    accept     = pipe.in_valid && advance[0];
    orphanIn   = !inPacket_q && !pipe.in_first;
    inPacket_d = accept ? !pipe.in_last : inPacket_q;
    finalRed   = nextVec[LAT-1][0];
    finalFirst = inFirst[LAT-1] || inOrphan[LAT-1];
    acc_d      = acc_q;
    if (advance[LAT-1] && inValid[LAT-1]) begin
      if (finalFirst) acc_d = finalRed;
      else            acc_d = inOp[LAT-1] ? (acc_q & finalRed) : (acc_q | finalRed);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stageValid_q  <= '0;
      stageVec_q    <= '0;
      stageOp_q     <= '0;
      stageFirst_q  <= '0;
      stageLast_q   <= '0;
      stageOrphan_q <= '0;
      inPacket_q    <= 1'b0;
      acc_q         <= 1'b0;
    end else begin
      inPacket_q <= inPacket_d;
      acc_q      <= acc_d;
      for (int s = 0; s < LAT; s++) begin
        if (advance[s]) begin
          stageValid_q[s] <= inValid[s];
          if (inValid[s]) begin
            stageVec_q[s]    <= nextVec[s];
            stageOp_q[s]     <= inOp[s];
            stageFirst_q[s]  <= inFirst[s];
            stageLast_q[s]   <= inLast[s];
            stageOrphan_q[s] <= inOrphan[s];
          end
        end
      end
    end
  end

  assign pipe.in_ready   = advance[0];
  assign pipe.out_valid  = stageValid_q[LAT-1];
  assign pipe.or_out     = stageVec_q[LAT-1][0];
  assign pipe.sticky_out = acc_q;
  assign pipe.out_last   = stageLast_q[LAT-1];
  assign pipe.out_orphan = stageOrphan_q[LAT-1];

  logic unusedBits;
  assign unusedBits = ^{stageVec_q[LAT-1][NP-1:1], stageOp_q[LAT-1], stageFirst_q[LAT-1]};

endmodule
